// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared types and constants for the program-counter sequencer.
//            Holds the sequencer state encoding and the architectural
//            PC constants (reset vector, halt address, sequential step).
// Revision : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

    // Fetch sequencing state: normal run, delay-slot pending, terminal halt.
    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_DELAY = 2'd1,
        SEQ_HALT  = 2'd2
    } pc_seq_state_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] PC_HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter controller for the instruction-fetch side of
//            the Harvard CPU. Boots from RESET_VECTOR, advances by 4 per
//            enabled cycle, performs MIPS branch-delay-slot sequencing and
//            halts permanently once a redirect to HALT_ADDR has retired its
//            delay slot.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            clk_enable, stall    - advance qualifiers (both freeze all state)
//            redirect_valid/target- taken branch/jump at the current pc
//            pc, fetch_en         - registered fetch address and its valid
//            in_delay_slot        - instruction at pc is a delay slot
//            active               - CPU running (low once halted)
//            slot_branch_err      - sticky: redirect seen inside a delay slot
//            fetch_count          - number of advances since reset
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_target,
    output logic [31:0]          pc,
    output logic                 fetch_en,
    output logic                 in_delay_slot,
    output logic                 active,
    output logic                 slot_branch_err,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    pc_seq_state_t        r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_pending_target;
    logic                 r_slot_err;
    logic [CNT_WIDTH-1:0] r_count;

    pc_seq_state_t        w_state_nxt;
    logic [31:0]          w_pc_nxt;
    logic [31:0]          w_pending_nxt;
    logic                 w_slot_err_nxt;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic                 w_advance;

    // ------------------------------------------------------------------
    // Next-state / next-value logic. Nothing changes unless advancing,
    // and the halt state never advances.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pending_nxt  = r_pending_target;
        w_slot_err_nxt = r_slot_err;
        w_count_nxt    = r_count;
        w_advance      = clk_enable & ~stall & (r_state != SEQ_HALT);

        if (w_advance) begin
            w_count_nxt = r_count + CNT_WIDTH'(1);
            case (r_state)
                SEQ_RUN: begin
                    // The instruction after the branch (delay slot) is
                    // always fetched; the target is only used one advance
                    // later.
                    w_pc_nxt = r_pc + PC_STEP;
                    if (redirect_valid) begin
                        w_pending_nxt = {redirect_target[31:2], 2'b00};
                        w_state_nxt   = SEQ_DELAY;
                    end
                end
                SEQ_DELAY: begin
                    w_pc_nxt    = r_pending_target;
                    w_state_nxt = (r_pending_target == HALT_ADDR) ? SEQ_HALT : SEQ_RUN;
                    // A branch in a delay slot is architecturally undefined;
                    // flag it and keep following the first target.
                    if (redirect_valid) begin
                        w_slot_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, pc and counter registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= SEQ_RUN;
            r_pc             <= RESET_VECTOR;
            r_pending_target <= 32'd0;
            r_slot_err       <= 1'b0;
            r_count          <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_pending_target <= w_pending_nxt;
            r_slot_err       <= w_slot_err_nxt;
            r_count          <= w_count_nxt;
        end
    end

    assign pc              = r_pc;
    assign in_delay_slot   = (r_state == SEQ_DELAY);
    assign active          = (r_state != SEQ_HALT);
    assign fetch_en        = (r_state != SEQ_HALT);
    assign slot_branch_err = r_slot_err;
    assign fetch_count     = r_count;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller for the program counter (PC) register and the instruction-fetch side of the Harvard CPU.
- Boots from the reset vector and advances the PC by 4 per enabled cycle.
- Implements MIPS branch-delay-slot sequencing for taken branches and jumps.
- Holds on memory stall and enters a terminal halt when a redirect to HALT_ADDR has retired its delay slot; drives the top-level `active` flag.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded by reset
HALT_ADDR, 32'h00000000, redirect target that halts the CPU after its delay slot
CNT_WIDTH, 32, width of the fetched-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
clk_enable  input  1  global advance enable; low freezes all state
stall  input  1  instruction-memory wait; high freezes all state
redirect_valid  input  1  instruction at current pc is a taken branch/jump
redirect_target  input  32  destination of that branch/jump
pc  output  32  current fetch address, registered
fetch_en  output  1  pc is a valid fetch request
in_delay_slot  output  1  instruction at pc is a delay-slot instruction
active  output  1  CPU running; low once halted
slot_branch_err  output  1  sticky: redirect seen while in delay slot
fetch_count  output  CNT_WIDTH  number of advances since reset

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset, on a clk edge with reset=1:
  - state=SEQ_RUN, pc=RESET_VECTOR, pending_target=0.
  - fetch_count=0, slot_branch_err=0.
  - Resulting outputs: active=1, fetch_en=1, in_delay_slot=0.
- Reset wins over every other input, including mid-delay-slot and in SEQ_HALT.
- advance = clk_enable & ~stall & (state != SEQ_HALT). When advance=0, every register holds its value.
- redirect_valid and redirect_target are sampled only on advance cycles. The source must hold them stable through a stall.
- Target alignment: the latched target is {redirect_target[31:2], 2'b00}.
- SEQ_RUN on advance:
  - pc <= pc + 4 (mod 2^32).
  - If redirect_valid: pending_target <= aligned target, state <= SEQ_DELAY.
- SEQ_DELAY on advance (the delay-slot instruction retires):
  - pc <= pending_target.
  - If pending_target == HALT_ADDR: state <= SEQ_HALT; otherwise state <= SEQ_RUN.
  - If redirect_valid: slot_branch_err <= 1 and the redirect is ignored.
- SEQ_HALT:
  - pc holds HALT_ADDR, active=0, fetch_en=0.
  - fetch_count frozen; only reset exits.
- Output decode (combinational from state):
  - in_delay_slot = (state == SEQ_DELAY).
  - active = fetch_en = (state != SEQ_HALT).
- fetch_count increments by 1 on each advance and wraps at 2^CNT_WIDTH.
- Latency: redirect seen at pc=P gives pc=P+4 next advance, then pc=target on the following advance. Stall cycles insert anywhere without loss.
- Wrap-around: sequential pc 32'hFFFFFFFC + 4 = 32'h00000000 stays in SEQ_RUN. Halt is entered only via redirect.
- Redirect to HALT_ADDR: the delay slot at P+4 is still fetched; pc=0 appears together with active=0 on the same edge.
- Redirect with clk_enable=0 or stall=1: not captured.

Decomposition:
- Shared package pc_seq_pkg holds:
  - Enum pc_seq_state_t {SEQ_RUN, SEQ_DELAY, SEQ_HALT}, 2 bits.
  - Constants PC_RESET_VECTOR = 32'hBFC00000, PC_HALT_ADDR = 32'h0, PC_STEP = 4.
- No sub-module is required. Next-PC select and the +4 increment stay inline; one always_ff for state/pc/counters, one always_comb for next-state.

Test Plan:
- Reset then 3 advances → pc = BFC00000, BFC00004, BFC00008, BFC0000C; fetch_count=3; active=1.
- redirect_valid=1, target=BFC00100 at pc=BFC00008 → pc BFC0000C with in_delay_slot=1, then BFC00100 with in_delay_slot=0.
- Same as previous with stall=1 for 2 cycles in SEQ_DELAY → pc holds BFC0000C for 2 cycles, then BFC00100; fetch_count unchanged during stall.
- Jump to 0 at pc=BFC00010 → pc=BFC00014 (slot), then pc=0 with active=0, fetch_en=0; further advances change nothing; reset → pc=BFC00000, active=1.
- redirect_valid in delay slot, target=BFC00200 → ignored; pc follows first target; slot_branch_err=1 until reset. Target BFC00103 → pc=BFC00100.
- Reset asserted in SEQ_DELAY → pc=BFC00000, state SEQ_RUN, pending target discarded. Sequential wrap from FFFFFFFC → pc=0, active stays 1.
